// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a one-cycle write strobe, with a write buffer ahead of the serialiser.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry circular FIFO; otherwise the buffer is one holding register.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       ovf,
    output logic       txd
);
    // state  | meaning
    // IDLE   | line high, waiting for a buffered byte
    // START  | driving the start bit (0)
    // DATA   | driving shift[0], LSB first, bit_idx counts 0..7
    // STOP   | driving the stop bit (1); chains straight into START if more data

    localparam int          DIV    = CLK_FREQ_HZ / BAUD;
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD must be at least 2");
        end
    endgenerate

    logic       empty;
    logic       push;
    logic       pop;
    logic [7:0] head;

    // full is the pre-pop view, so a write in a popping cycle still sees the old occupancy
    assign push = wr_en & ~full;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_check
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    // push only happens while empty and pop only while valid, so they never coincide
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= wr_data;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign full  = hold_valid;
    assign empty = ~hold_valid;
    assign head  = hold_data;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [15:0] cnt;
    logic [15:0] cnt_d;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_d;
    logic [7:0]  shift;
    logic [7:0]  shift_d;
    logic        txd_d;
    logic        bit_done;

    assign bit_done = (cnt == 16'd0);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        txd_d     = txd;
        pop       = 1'b0;
        if (state != S_IDLE && !bit_done) begin
            cnt_d = cnt - 16'd1;
        end
        case (state)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = DIV_M1;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d     = DIV_M1;
                    bit_idx_d = 3'd0;
                    txd_d     = shift[0];
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = DIV_M1;
                    if (bit_idx == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift[7:1]};
                        txd_d     = shift[1];
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        cnt_d   = DIV_M1;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            txd     <= txd_d;
        end
    end

    assign busy = (state != S_IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a frame-level reference model predicts line and flags each cycle,
// and a serial monitor decodes frames from txd and checks them against the queue of accepted bytes.
module tb_uart_tx_fifo;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD_R = 100_000;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD_R;
    localparam int FRAME  = 10 * DIV;
`ifdef UART_TX_FIFO_EN
    localparam int M_DEPTH = DEPTH;
`else
    localparam int M_DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       busy;
    logic       ovf;
    logic       txd;

    uart_tx_fifo #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD       (BAUD_R),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .busy   (busy),
        .ovf    (ovf),
        .txd    (txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the start time of the frame on the line.
    int unsigned m_t      = 0;
    int unsigned m_start  = 0;
    bit          m_active = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_valid  = 1'b0;
    bit          m_was_full;
    int          m_epoch  = 0;
    logic [7:0]  m_cur    = 8'h00;
    logic [7:0]  m_buf[$];
    logic [7:0]  exp_q[$];

    always @(posedge clk) begin
        m_t++;
        if (!resetn) begin
            m_buf.delete();
            exp_q.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
            m_valid  = 1'b1;
            m_epoch++;
        end else begin
            m_was_full = (m_buf.size() == M_DEPTH);
            if (m_active && (m_t - m_start == FRAME)) begin
                m_active = 1'b0;
            end
            if (!m_active && m_buf.size() != 0) begin
                m_cur    = m_buf.pop_front();
                m_active = 1'b1;
                m_start  = m_t;
            end
            if (wr_en) begin
                if (m_was_full) begin
                    m_ovf = 1'b1;
                end else begin
                    m_buf.push_back(wr_data);
                    exp_q.push_back(wr_data);
                end
            end
        end
    end

    function automatic logic model_txd();
        int off;
        if (!m_active) return 1'b1;
        off = int'(m_t - m_start) / DIV;
        if (off == 0) return 1'b0;
        if (off <= 8) return m_cur[off-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("txd", txd, model_txd());
            check("busy", busy, m_active || (m_buf.size() != 0));
            check("full", full, m_buf.size() == M_DEPTH);
            check("ovf", ovf, m_ovf);
        end
    end

    // Serial monitor: decodes frames at mid-bit and checks them against the scoreboard.
    bit         mon_busy = 1'b0;
    int         mon_k    = 0;
    int         mon_ep   = 0;
    logic [9:0] mon_bits = '0;

    always @(negedge clk) begin
        if (!mon_busy) begin
            if (m_valid && txd === 1'b0) begin
                mon_busy = 1'b1;
                mon_k    = 0;
                mon_ep   = m_epoch;
            end
        end else begin
            mon_k++;
        end
        if (mon_busy && mon_ep != m_epoch) begin
            mon_busy = 1'b0;
        end
        if (mon_busy && (mon_k % DIV) == DIV / 2) begin
            mon_bits[mon_k / DIV] = txd;
            if (mon_k / DIV == 9) begin
                mon_busy = 1'b0;
                check("start_bit", mon_bits[0], 1'b0);
                check("stop_bit", mon_bits[9], 1'b1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_byte: actual %02h required no frame (time %0t)", mon_bits[8:1], $time);
                end else begin
                    check("frame_byte", mon_bits[8:1], exp_q.pop_front());
                end
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_idle"}, done, 1'b1);
    endtask

    int  rate;
    bit  hit;

    initial begin
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_full", full, 1'b0);
        check("reset_ovf", ovf, 1'b0);

        wr(8'h55);
        check("single_busy", busy, 1'b1);
        wait_idle(2 * FRAME, "single");
        check("single_ovf", ovf, 1'b0);

        wr(8'h41);
        wr(8'h42);
        wait_idle(3 * FRAME, "b2b");

        for (int i = 0; i < 6; i++) begin
            wr(8'(8'hA0 + i));
        end
        check("burst_ovf", ovf, 1'b1);
        wait_idle(8 * FRAME, "burst");

        // reset sampled at the 35th edge after the write, in the middle of the data bits
        wr(8'hFF);
        repeat (34) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_quiet", txd, 1'b1);
        wr(8'h0F);
        wait_idle(2 * FRAME, "post_rst");

        // fill the buffer behind a frame, then write on the edge that pops the next entry
        wr(8'hC0);
        @(negedge clk);
        for (int i = 1; i < 20 && m_buf.size() < M_DEPTH; i++) begin
            wr(8'(8'hC0 + i));
        end
        check("fill_full", full, 1'b1);
        check("fill_ovf", ovf, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            if (m_active && (m_t + 1 == m_start + FRAME)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("collide_sync", hit, 1'b1);
        wr(8'hEE);
        check("collide_ovf", ovf, 1'b1);
        check("collide_full", full, 1'b0);
        wait_idle((M_DEPTH + 2) * FRAME, "collide");

        for (int seg = 0; seg < 8; seg++) begin
            rate = int'($urandom_range(1, 8));
            for (int c = 0; c < 500; c++) begin
                wr_en   = ($urandom_range(0, 99) < rate);
                wr_data = 8'($urandom);
                @(negedge clk);
            end
        end
        wr_en = 1'b0;
        wait_idle((M_DEPTH + 2) * FRAME, "random");
        repeat (DIV) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
